// File: rtl/mem_arbiter.sv
// Two-master (framebuffer / CPU) arbiter in front of ssram_ctrl with fb priority and a CPU starvation guard.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
  parameter logic [1:0] ID_FB      = 2'd3,
  parameter int         MAX_FB_RUN = 8,
  parameter int         RUN_W      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fb_read,
  input  logic [29:0] fb_address,
  output logic        fb_waitrequest,
  input  logic [1:0]  cpu_id,
  input  logic [29:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_writedatamask,
  output logic        cpu_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic        mem_waitrequest,
  output logic [31:0] stat_fb_grants,
  output logic [31:0] stat_cpu_grants,
  output logic [31:0] stat_cpu_stall
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK_FB  = 2'd1,
    LOCK_CPU = 2'd2
  } lock_t;

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_FB_RUN);

  lock_t            state;
  lock_t            state_next;
  logic [RUN_W-1:0] run;
  logic             fb_req;
  logic             cpu_req;
  logic             starve;
  logic             sel_fb;
  logic             sel_cpu;
  logic             fb_accept;
  logic             cpu_accept;

  assign fb_req     = fb_read;
  assign cpu_req    = cpu_read | cpu_write;
  assign starve     = (MAX_FB_RUN != 0) && (run == RUN_MAX);
  assign fb_accept  = sel_fb & fb_req & ~mem_waitrequest;
  assign cpu_accept = sel_cpu & cpu_req & ~mem_waitrequest;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= UNLOCKED;
    end else begin
      state <= state_next;
    end
  end

  // A master stalled by the memory keeps the port until its request is taken.
  always_comb begin
    sel_fb            = 1'b0;
    sel_cpu           = 1'b0;
    state_next        = UNLOCKED;
    mem_id            = cpu_id;
    mem_address       = cpu_address;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_writedata     = cpu_writedata;
    mem_writedatamask = cpu_writedatamask;

    case (state)
      LOCK_FB:  sel_fb  = 1'b1;
      LOCK_CPU: sel_cpu = 1'b1;
      default: begin
        if (cpu_req && (!fb_req || starve)) begin
          sel_cpu = 1'b1;
        end else if (fb_req) begin
          sel_fb = 1'b1;
        end
      end
    endcase

    if (sel_fb && fb_req && mem_waitrequest) begin
      state_next = LOCK_FB;
    end else if (sel_cpu && cpu_req && mem_waitrequest) begin
      state_next = LOCK_CPU;
    end

    if (sel_fb) begin
      mem_id      = ID_FB;
      mem_address = fb_address;
      mem_read    = 1'b1;
    end else if (sel_cpu) begin
      mem_read  = cpu_read;
      mem_write = cpu_write;
    end
  end

  assign fb_waitrequest  = mem_waitrequest | ~sel_fb;
  assign cpu_waitrequest = mem_waitrequest | ~sel_cpu;

  // Counts fb wins only while the CPU is actually waiting; any CPU grant or idle CPU restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run <= '0;
    end else if (cpu_accept || !cpu_req) begin
      run <= '0;
    end else if (fb_accept && run != RUN_MAX) begin
      run <= run + RUN_W'(1);
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic cpu_stalled;

  assign cpu_stalled = cpu_req & cpu_waitrequest;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_fb_grants  <= '0;
      stat_cpu_grants <= '0;
      stat_cpu_stall  <= '0;
    end else begin
      if (fb_accept && stat_fb_grants != 32'hFFFF_FFFF) begin
        stat_fb_grants <= stat_fb_grants + 32'd1;
      end
      if (cpu_accept && stat_cpu_grants != 32'hFFFF_FFFF) begin
        stat_cpu_grants <= stat_cpu_grants + 32'd1;
      end
      if (cpu_stalled && stat_cpu_stall != 32'hFFFF_FFFF) begin
        stat_cpu_stall <= stat_cpu_stall + 32'd1;
      end
    end
  end
`else
  assign stat_fb_grants  = 32'd0;
  assign stat_cpu_grants = 32'd0;
  assign stat_cpu_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random Avalon traffic against a reference model.
// Runs one instance with MAX_FB_RUN=8 and one with MAX_FB_RUN=0 on shared inputs.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        fb_read;
  logic [29:0] fb_address;
  logic [1:0]  cpu_id;
  logic [29:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_writedatamask;
  logic        mem_waitrequest;

  logic        fb_waitrequest, cpu_waitrequest, mem_read, mem_write;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] stat_fb_grants, stat_cpu_grants, stat_cpu_stall;

  logic        z_fb_waitrequest, z_cpu_waitrequest, z_mem_read, z_mem_write;
  logic [1:0]  z_mem_id;
  logic [29:0] z_mem_address;
  logic [31:0] z_mem_writedata;
  logic [3:0]  z_mem_writedatamask;
  logic [31:0] z_stat_fb_grants, z_stat_cpu_grants, z_stat_cpu_stall;

  int errors = 0;
  int checks = 0;

  // Reference model: owner 0=nobody, 1=fb, 2=cpu; streak = fb wins while the cpu waits.
  int m_owner[2];
  int m_streak[2];
  int m_max[2];
  int cur_sel[2];
  int fb_count, cpu_count, stall_count;
  bit last_fb_acc, last_cpu_acc;

  always #5 clock = ~clock;

  mem_arbiter #(.ID_FB(2'd3), .MAX_FB_RUN(8), .RUN_W(8)) dut (
    .clock(clock), .reset(reset),
    .fb_read(fb_read), .fb_address(fb_address), .fb_waitrequest(fb_waitrequest),
    .cpu_id(cpu_id), .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_writedatamask(cpu_writedatamask),
    .cpu_waitrequest(cpu_waitrequest),
    .mem_id(mem_id), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_writedatamask(mem_writedatamask),
    .mem_waitrequest(mem_waitrequest),
    .stat_fb_grants(stat_fb_grants), .stat_cpu_grants(stat_cpu_grants),
    .stat_cpu_stall(stat_cpu_stall)
  );

  mem_arbiter #(.ID_FB(2'd3), .MAX_FB_RUN(0), .RUN_W(8)) dut0 (
    .clock(clock), .reset(reset),
    .fb_read(fb_read), .fb_address(fb_address), .fb_waitrequest(z_fb_waitrequest),
    .cpu_id(cpu_id), .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_writedatamask(cpu_writedatamask),
    .cpu_waitrequest(z_cpu_waitrequest),
    .mem_id(z_mem_id), .mem_address(z_mem_address), .mem_read(z_mem_read),
    .mem_write(z_mem_write),
    .mem_writedata(z_mem_writedata), .mem_writedatamask(z_mem_writedatamask),
    .mem_waitrequest(mem_waitrequest),
    .stat_fb_grants(z_stat_fb_grants), .stat_cpu_grants(z_stat_cpu_grants),
    .stat_cpu_stall(z_stat_cpu_stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit cpuWants();
    return cpu_read | cpu_write;
  endfunction

  function automatic int modelSel(int k);
    if (m_owner[k] != 0) return m_owner[k];
    if (cpuWants() && (!fb_read || (m_max[k] > 0 && m_streak[k] >= m_max[k]))) return 2;
    if (fb_read) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] expId(int s);
    return (s == 1) ? 32'd3 : 32'(cpu_id);
  endfunction

  function automatic logic [31:0] expAddr(int s);
    return (s == 1) ? 32'(fb_address) : 32'(cpu_address);
  endfunction

  function automatic logic [31:0] expRead(int s);
    return (s == 1) ? 32'd1 : ((s == 2) ? 32'(cpu_read) : 32'd0);
  endfunction

  function automatic logic [31:0] expWrite(int s);
    return (s == 2) ? 32'(cpu_write) : 32'd0;
  endfunction

  function automatic logic [31:0] expWait(int s, int who);
    return 32'(mem_waitrequest || (s != who));
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k]  = 0;
      m_streak[k] = 0;
    end
    fb_count     = 0;
    cpu_count    = 0;
    stall_count  = 0;
    last_fb_acc  = 1'b0;
    last_cpu_acc = 1'b0;
  endtask

  // Samples combinational outputs mid-cycle and compares both instances with the model.
  task automatic evalCycle();
    @(negedge clock);
    #1;
    for (int k = 0; k < 2; k++) cur_sel[k] = modelSel(k);
    checkOutput("mem_id", 32'(mem_id), expId(cur_sel[0]));
    checkOutput("mem_address", 32'(mem_address), expAddr(cur_sel[0]));
    checkOutput("mem_read", 32'(mem_read), expRead(cur_sel[0]));
    checkOutput("mem_write", 32'(mem_write), expWrite(cur_sel[0]));
    checkOutput("mem_writedata", mem_writedata, cpu_writedata);
    checkOutput("mem_writedatamask", 32'(mem_writedatamask), 32'(cpu_writedatamask));
    checkOutput("fb_waitrequest", 32'(fb_waitrequest), expWait(cur_sel[0], 1));
    checkOutput("cpu_waitrequest", 32'(cpu_waitrequest), expWait(cur_sel[0], 2));
`ifdef MEM_ARB_STATS_EN
    checkOutput("stat_fb_grants", stat_fb_grants, 32'(fb_count));
    checkOutput("stat_cpu_grants", stat_cpu_grants, 32'(cpu_count));
    checkOutput("stat_cpu_stall", stat_cpu_stall, 32'(stall_count));
`else
    checkOutput("stat_fb_grants", stat_fb_grants, 32'd0);
    checkOutput("stat_cpu_grants", stat_cpu_grants, 32'd0);
    checkOutput("stat_cpu_stall", stat_cpu_stall, 32'd0);
`endif
    checkOutput("z_mem_id", 32'(z_mem_id), expId(cur_sel[1]));
    checkOutput("z_mem_address", 32'(z_mem_address), expAddr(cur_sel[1]));
    checkOutput("z_mem_read", 32'(z_mem_read), expRead(cur_sel[1]));
    checkOutput("z_mem_write", 32'(z_mem_write), expWrite(cur_sel[1]));
    checkOutput("z_fb_waitrequest", 32'(z_fb_waitrequest), expWait(cur_sel[1], 1));
    checkOutput("z_cpu_waitrequest", 32'(z_cpu_waitrequest), expWait(cur_sel[1], 2));
  endtask

  // Advances the model across the clock edge using the inputs held during the cycle.
  task automatic commitCycle();
    @(posedge clock);
    if (reset) begin
      modelReset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        int  s;
        bit  req;
        bit  acc;
        s   = cur_sel[k];
        req = (s == 1) ? fb_read : ((s == 2) ? cpuWants() : 1'b0);
        acc = req && !mem_waitrequest;
        if (k == 0) begin
          last_fb_acc  = acc && (s == 1);
          last_cpu_acc = acc && (s == 2);
          if (last_fb_acc) fb_count++;
          if (last_cpu_acc) cpu_count++;
          if (cpuWants() && (mem_waitrequest || s != 2)) stall_count++;
        end
        m_owner[k] = (req && mem_waitrequest) ? s : 0;
        if (!cpuWants() || (acc && s == 2)) m_streak[k] = 0;
        else if (acc && s == 1 && m_streak[k] < m_max[k]) m_streak[k]++;
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input bit fr, input bit cr, input bit cw, input bit mw);
    fb_read         = fr;
    cpu_read        = cr;
    cpu_write       = cw;
    mem_waitrequest = mw;
  endtask

  task automatic randomNext();
    if (!fb_read || last_fb_acc) begin
      fb_read    = ($urandom_range(0, 2) != 0);
      fb_address = 30'($urandom);
    end
    if (!cpuWants() || last_cpu_acc) begin
      int r;
      r                 = $urandom_range(0, 3);
      cpu_read          = (r == 1);
      cpu_write         = (r == 2);
      cpu_id            = 2'($urandom_range(0, 2));
      cpu_address       = 30'($urandom);
      cpu_writedata     = $urandom;
      cpu_writedatamask = 4'($urandom);
    end
    mem_waitrequest = ($urandom_range(0, 9) < 4);
  endtask

  initial begin
    m_max[0] = 8;
    m_max[1] = 0;
    modelReset();
    reset             = 1'b1;
    fb_address        = 30'h0ABCDEF;
    cpu_id            = 2'd1;
    cpu_address       = 30'h1234567;
    cpu_writedata     = 32'hDEADBEEF;
    cpu_writedatamask = 4'hA;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state: idle port, both masters stalled.
    evalCycle();
    checkOutput("reset_mem_read", 32'(mem_read), 32'd0);
    checkOutput("reset_fb_wait", 32'(fb_waitrequest), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single CPU read with fb idle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    evalCycle();
    checkOutput("single_mem_read", 32'(mem_read), 32'd1);
    checkOutput("single_mem_id", 32'(mem_id), 32'd1);
    checkOutput("single_cpu_wait", 32'(cpu_waitrequest), 32'd0);
    commitCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    evalCycle();
    commitCycle();

    // Both masters streaming: 8 fb grants then one cpu grant, repeating.
    cpu_id = 2'd2;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      evalCycle();
      checkOutput("stream_mem_id", 32'(mem_id), (i % 9 == 8) ? 32'd2 : 32'd3);
      checkOutput("stream_z_cpu_wait", 32'(z_cpu_waitrequest), 32'd1);
      commitCycle();
    end

    // CPU write held across waitrequest while fb_read rises.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    evalCycle();
    commitCycle();
    cpu_address = 30'h2000111;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i >= 1, 1'b0, 1'b1, i < 3);
      evalCycle();
      checkOutput("held_mem_write", 32'(mem_write), 32'd1);
      checkOutput("held_mem_address", 32'(mem_address), 32'h2000111);
      commitCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    evalCycle();
    checkOutput("after_write_fb_wait", 32'(fb_waitrequest), 32'd0);
    commitCycle();

    // Reset during a locked fb transfer.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    evalCycle();
    commitCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    modelReset();
    evalCycle();
    checkOutput("reset_cpu_wait", 32'(cpu_waitrequest), 32'd0);
    commitCycle();
    reset = 1'b0;
    evalCycle();
    checkOutput("post_reset_cpu_wait", 32'(cpu_waitrequest), 32'd0);
    checkOutput("post_reset_mem_read", 32'(mem_read), 32'd1);
    commitCycle();

    // 90 streaming accepts from a fresh reset.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    modelReset();
    evalCycle();
    commitCycle();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 90; i++) begin
      evalCycle();
      commitCycle();
    end
`ifdef MEM_ARB_STATS_EN
    checkOutput("stats90_fb", stat_fb_grants, 32'd80);
    checkOutput("stats90_cpu", stat_cpu_grants, 32'd10);
    checkOutput("stats90_stall", stat_cpu_stall, 32'd80);
`else
    checkOutput("stats90_fb", stat_fb_grants, 32'd0);
    checkOutput("stats90_cpu", stat_cpu_grants, 32'd0);
    checkOutput("stats90_stall", stat_cpu_stall, 32'd0);
`endif

    // Random Avalon-compliant traffic for the MAX_FB_RUN=8 instance.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    last_fb_acc  = 1'b0;
    last_cpu_acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      randomNext();
      evalCycle();
      commitCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
